// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for branch resolution: FSM state, training entry,
// index width and the mispredict rule used by the EX compare.
package branch_resolve_ctrl_pkg;

  localparam int IDX_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic             taken;
    logic [IDX_W-1:0] idx;
  } upd_entry_t;

  function automatic logic mispredict(
    input logic        is_br,
    input logic        is_jmp,
    input logic        pred,
    input logic [31:0] ppc,
    input logic        act,
    input logic [31:0] tgt
  );
    logic m;
    m = 1'b0;
    if (is_br) begin
      m = (act != pred) |
          (act & (tgt != ppc));
    end else if (is_jmp) begin
      m = ~pred | (tgt != ppc);
    end
    return m;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_pred_upd_fifo.sv
// pred_upd_fifo: predictor-training queue, DEPTH entries (power of 2).
// Ports: push/din in, pop in, dout/full/empty out; async active-low rst.
module pred_upd_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  upd_entry_t din,
  output upd_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  upd_entry_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve control: mispredict detect, flush FSM, training queue.
// In: clk, rst(n), rdy, ex_*, upd_ready. Out: stall_ex, failed,
// redirect_pc, upd_valid/taken/pc_idx. Macro BRANCH_STATS_EN adds
// stat_branches / stat_mispred saturating counters.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ex_valid,
  input  logic        ex_is_btype,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_jump,
  input  logic [31:0] ex_pred_pc,
  input  logic        ex_actual_jump,
  input  logic [31:0] ex_target,
  output logic        stall_ex,
  output logic        failed,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic        upd_taken,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred,
`endif
  output logic [3:0]  upd_pc_idx
);

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [31:0] redir_q;
  logic [31:0] redir_d;

  logic        in_run;
  logic        accept;
  logic        mp;
  logic        take_mp;
  logic        taken;
  logic [31:0] new_pc;
  logic        push;
  logic        pop;
  logic        q_full;
  logic        q_empty;
  upd_entry_t  q_din;
  upd_entry_t  q_dout;

  assign in_run   = (state_q == RUN);
  assign stall_ex = q_full & ex_valid &
                    ex_is_btype & in_run;
  assign accept   = ex_valid & rdy &
                    in_run & ~stall_ex;

  assign mp = mispredict(ex_is_btype,
                         ex_is_jump,
                         ex_pred_jump,
                         ex_pred_pc,
                         ex_actual_jump,
                         ex_target);

  assign take_mp = accept & mp;

  // Jumps always transfer control.
  assign taken  = ex_is_btype ?
                  ex_actual_jump : 1'b1;
  assign new_pc = taken ? ex_target :
                  ex_pc + 32'd4;

  assign push      = accept & ex_is_btype;
  assign pop       = ~q_empty & upd_ready & rdy;
  assign q_din     = '{taken: ex_actual_jump,
                       idx:   ex_pc[5:2]};

  assign failed      = (state_q == FLUSH);
  assign redirect_pc = redir_q;
  assign upd_valid   = ~q_empty;
  assign upd_taken   = q_dout.taken;
  assign upd_pc_idx  = q_dout.idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    redir_d = redir_q;
    if (rdy) begin
      unique case (state_q)
        RUN: begin
          if (take_mp) begin
            state_d = FLUSH;
            cnt_d   = FC_INIT;
            redir_d = new_pc;
          end
        end
        FLUSH: begin
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      redir_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
    end
  end

  pred_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= 32'd0;
      stat_mispred  <= 32'd0;
    end else begin
      if (push && stat_branches != '1) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (take_mp && stat_mispred != '1) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table,
// corner sequences, and randomized cycles against a queue model.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ex_valid;
  logic        ex_is_btype;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_pred_jump;
  logic [31:0] ex_pred_pc;
  logic        ex_actual_jump;
  logic [31:0] ex_target;
  logic        stall_ex;
  logic        failed;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic        upd_taken;
  logic [3:0]  upd_pc_idx;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_ctrl #(
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .ex_valid       (ex_valid),
    .ex_is_btype    (ex_is_btype),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_pred_jump   (ex_pred_jump),
    .ex_pred_pc     (ex_pred_pc),
    .ex_actual_jump (ex_actual_jump),
    .ex_target      (ex_target),
    .stall_ex       (stall_ex),
    .failed         (failed),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_taken      (upd_taken),
`ifdef BRANCH_STATS_EN
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred),
`endif
    .upd_pc_idx     (upd_pc_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        br;
    logic        jmp;
    logic [31:0] pc;
    logic        pj;
    logic [31:0] ppc;
    logic        aj;
    logic [31:0] tgt;
    logic        e_fail;
    logic [31:0] e_redir;
    logic        e_enq;
    logic        e_taken;
    logic [3:0]  e_idx;
  } vec_t;

  function automatic vec_t mk(
    input string n, input logic br, input logic jmp,
    input logic [31:0] pc, input logic pj,
    input logic [31:0] ppc, input logic aj,
    input logic [31:0] tgt, input logic ef,
    input logic [31:0] er, input logic ee,
    input logic et, input logic [3:0] ei);
    vec_t v;
    v.name = n; v.br = br; v.jmp = jmp; v.pc = pc;
    v.pj = pj; v.ppc = ppc; v.aj = aj; v.tgt = tgt;
    v.e_fail = ef; v.e_redir = er; v.e_enq = ee;
    v.e_taken = et; v.e_idx = ei;
    return v;
  endfunction

  task automatic idle();
    ex_valid = 1'b0; ex_is_btype = 1'b0;
    ex_is_jump = 1'b0; ex_pc = '0;
    ex_pred_jump = 1'b0; ex_pred_pc = '0;
    ex_actual_jump = 1'b0; ex_target = '0;
  endtask

  task automatic drive(input logic br, input logic jmp,
                       input logic [31:0] pc, input logic pj,
                       input logic [31:0] ppc, input logic aj,
                       input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_btype = br;
    ex_is_jump = jmp; ex_pc = pc;
    ex_pred_jump = pj; ex_pred_pc = ppc;
    ex_actual_jump = aj; ex_target = tgt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int fc;
    int pops;
    @(negedge clk);
    drive(v.br, v.jmp, v.pc, v.pj, v.ppc, v.aj, v.tgt);
    upd_ready = 1'b0;
    #1;
    check({v.name, "_stall"}, 32'(stall_ex), 0);
    @(posedge clk); #1;
    idle();
    check({v.name, "_failed"}, 32'(failed), 32'(v.e_fail));
    if (v.e_fail)
      check({v.name, "_redir"}, redirect_pc, v.e_redir);
    check({v.name, "_uvalid"}, 32'(upd_valid), 32'(v.e_enq));
    if (v.e_enq) begin
      check({v.name, "_utaken"}, 32'(upd_taken), 32'(v.e_taken));
      check({v.name, "_uidx"}, 32'(upd_pc_idx), 32'(v.e_idx));
    end
    fc = int'(failed);
    if (failed)
      drive(1'b1, 1'b0, 32'h3C, 1'b0, 32'h0, 1'b1, 32'h40);
    for (int i = 0; i < 10 && failed; i++) begin
      @(posedge clk); #1;
      if (failed) fc++;
    end
    idle();
    check({v.name, "_flushlen"}, 32'(fc), v.e_fail ? FC : 0);
    upd_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8 && upd_valid; i++) begin
      @(posedge clk); #1;
      pops++;
    end
    upd_ready = 1'b0;
    check({v.name, "_entries"}, 32'(pops), 32'(v.e_enq));
  endtask

  vec_t vecs[10];

  // Reference model state
  typedef struct {
    logic       taken;
    logic [3:0] idx;
  } ment_t;
  ment_t       m_q[$];
  int          m_flush;
  logic [31:0] m_redir;

  function automatic logic m_mp(input int kind,
    input logic pj, input logic [31:0] ppc,
    input logic aj, input logic [31:0] tgt);
    if (kind == 0)
      return (aj != pj) || (aj && tgt != ppc);
    if (kind == 1)
      return !pj || tgt != ppc;
    return 1'b0;
  endfunction

  initial begin
    logic [3:0] got[$];
    logic       acc_pend;
    int         kind;
    logic       m_stall;
    logic       m_acc;
    logic [31:0] s_b0;
    logic [31:0] s_m0;

    rst = 1'b0;
    rdy = 1'b1;
    upd_ready = 1'b0;
    idle();
    #12;
    check("reset_failed", 32'(failed), 0);
    check("reset_redir", redirect_pc, 0);
    check("reset_uvalid", 32'(upd_valid), 0);
    check("reset_utaken", 32'(upd_taken), 0);
    check("reset_uidx", 32'(upd_pc_idx), 0);
    check("reset_stall", 32'(stall_ex), 0);
    @(negedge clk);
    rst = 1'b1;

    vecs[0] = mk("nt_ok", 1, 0, 32'h100, 0, 32'h0, 0,
                 32'h180, 0, 32'h0, 1, 0, 4'h0);
    vecs[1] = mk("nt_to_t", 1, 0, 32'h204, 0, 32'h208, 1,
                 32'h300, 1, 32'h300, 1, 1, 4'h1);
    vecs[2] = mk("t_to_nt", 1, 0, 32'h1FC, 1, 32'h280, 0,
                 32'h280, 1, 32'h200, 1, 0, 4'hF);
    vecs[3] = mk("t_ok", 1, 0, 32'h3C8, 1, 32'h400, 1,
                 32'h400, 0, 32'h0, 1, 1, 4'h2);
    vecs[4] = mk("t_badtgt", 1, 0, 32'h10, 1, 32'h40, 1,
                 32'h80, 1, 32'h80, 1, 1, 4'h4);
    vecs[5] = mk("j_ok", 0, 1, 32'h500, 1, 32'h600, 1,
                 32'h600, 0, 32'h0, 0, 0, 4'h0);
    vecs[6] = mk("j_nopred", 0, 1, 32'h504, 0, 32'h0, 1,
                 32'h700, 1, 32'h700, 0, 0, 4'h0);
    vecs[7] = mk("j_badtgt", 0, 1, 32'h508, 1, 32'h800, 1,
                 32'h804, 1, 32'h804, 0, 0, 4'h0);
    vecs[8] = mk("wrap", 1, 0, 32'hFFFFFFFC, 1, 32'h10, 0,
                 32'h10, 1, 32'h0, 1, 0, 4'hF);
    vecs[9] = mk("nt_tgt_ign", 1, 0, 32'h24, 0, 32'h999, 0,
                 32'h123, 0, 32'h0, 1, 0, 4'h9);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: 5th branch stalls until the queue drains.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'(i * 4), 1'b0, 32'h0,
            1'b0, 32'h0);
      #1;
      check("bp_stall", 32'(stall_ex), i < 4 ? 0 : 1);
    end
    upd_ready = 1'b1;
    acc_pend = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (upd_valid) got.push_back(upd_pc_idx);
      acc_pend = ex_valid && !stall_ex;
      @(posedge clk); #1;
      if (acc_pend) idle();
    end
    upd_ready = 1'b0;
    check("bp_count", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check("bp_order", 32'(got[i]), 32'(i));

    // Async reset in the 2nd flush cycle with 3 queued entries.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'(i * 4), 1'b0, 32'h0,
            i == 2 ? 1'b1 : 1'b0, 32'h900);
    end
    @(posedge clk); #1;
    idle();
    check("ar_flush1", 32'(failed), 1);
    @(posedge clk); #1;
    check("ar_flush2", 32'(failed), 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_failed", 32'(failed), 0);
    check("ar_uvalid", 32'(upd_valid), 0);
    check("ar_redir", redirect_pc, 0);
    check("ar_uidx", 32'(upd_pc_idx), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ar_after", 32'(failed), 0);

    // rdy low for 3 cycles mid-flush.
`ifdef BRANCH_STATS_EN
    s_b0 = stat_branches;
    s_m0 = stat_mispred;
`else
    s_b0 = '0;
    s_m0 = '0;
`endif
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h204, 1'b0, 32'h0, 1'b1, 32'h300);
    @(posedge clk); #1;
    idle();
    rdy = 1'b0;
    upd_ready = 1'b1;
    check("rdy_f0", 32'(failed), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rdy_hold", 32'(failed), 1);
      check("rdy_qhold", 32'(upd_valid), 1);
    end
    rdy = 1'b1;
    upd_ready = 1'b0;
    @(posedge clk); #1;
    check("rdy_en1", 32'(failed), 1);
    @(posedge clk); #1;
    check("rdy_en2", 32'(failed), 0);
    check("rdy_redir", redirect_pc, 32'h300);
`ifdef BRANCH_STATS_EN
    check("stat_mp", stat_mispred - s_m0, 1);
    check("stat_br", stat_branches - s_b0, 1);
`endif

    // Randomized cycles against the queue model.
    do_reset();
    m_q = {};
    m_flush = 0;
    m_redir = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 9) != 0);
      upd_ready = $urandom_range(0, 1) == 1;
      kind = $urandom_range(0, 2);
      ex_valid = $urandom_range(0, 9) < 6;
      ex_is_btype = (kind == 0);
      ex_is_jump = (kind == 1);
      ex_pc = $urandom;
      ex_target = $urandom;
      ex_actual_jump = (kind == 1) ? 1'b1 :
                       1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_jump = ex_actual_jump;
        ex_pred_pc = ex_target;
      end else begin
        ex_pred_jump = 1'($urandom_range(0, 1));
        ex_pred_pc = ($urandom_range(0, 1) == 1) ?
                     ex_target : $urandom;
      end
      #1;
      m_stall = (m_q.size() == DEPTH) && ex_valid &&
                kind == 0 && m_flush == 0;
      check("rand_stall", 32'(stall_ex), 32'(m_stall));
      m_acc = ex_valid && rdy && m_flush == 0 && !m_stall;
      if (rdy) begin
        if (m_flush > 0) m_flush--;
        if (m_q.size() > 0 && upd_ready)
          void'(m_q.pop_front());
        if (m_acc && kind == 0)
          m_q.push_back('{ex_actual_jump, ex_pc[5:2]});
        if (m_acc && m_mp(kind, ex_pred_jump, ex_pred_pc,
                          ex_actual_jump, ex_target)) begin
          m_flush = FC;
          m_redir = (kind == 1 || ex_actual_jump) ?
                    ex_target : ex_pc + 32'd4;
        end
      end
      @(posedge clk); #1;
      check("rand_failed", 32'(failed), 32'(m_flush > 0));
      check("rand_redir", redirect_pc, m_redir);
      check("rand_uvalid", 32'(upd_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("rand_utaken", 32'(upd_taken),
              32'(m_q[0].taken));
        check("rand_uidx", 32'(upd_pc_idx), 32'(m_q[0].idx));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
